// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//
// Central stall/flush sequencer for the 5-stage pipeline. Drives the PC,
// IF/ID, ID/EX and EX/MEM write-enable and flush controls from load-use
// hazards, taken branches resolved in ID, fetch wait, data-memory wait and
// multi-cycle mult/div instructions. Also keeps saturating stall and flush
// performance counters.
//
// Ports:
//   clock, reset_n            pipeline clock, async active-low reset
//   id_rs, id_rt              source register fields of the ID instruction
//   id_uses_rs, id_uses_rt    ID instruction actually reads rs / rt
//   id_muldiv                 ID instruction is mult/div
//   id_branch_taken           branch in ID resolved taken this cycle
//   ex_mem_read, ex_rd        EX instruction is a load, and its destination
//   imem_ready                fetch data valid this cycle
//   dmem_busy                 MEM-stage access not complete
//   counter_clear             synchronous clear of both perf counters
//   pc_write .. ex_mem_write  combinational pipeline controls
//   stall_count, flush_count  saturating perf counters
//
// FSM states:
//   state  | meaning
//   RUN    | normal decode; hazard rules evaluated on the ID instruction
//   MULDIV | mult/div held in ID; front end stalled until cnt reaches 1

module pipeline_hazard_controller #(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_muldiv,
  input  logic        id_branch_taken,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        imem_ready,
  input  logic        dmem_busy,
  input  logic        counter_clear,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_write,
  output logic        id_ex_flush,
  output logic        ex_mem_write,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  typedef enum logic {S_RUN = 1'b0, S_MULDIV = 1'b1} state_t;

  localparam logic [7:0]  CNT_LOAD = 8'(MULDIV_CYCLES - 1);
  localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        muldiv_done_q, muldiv_done_d;
  logic [31:0] stall_cnt_q, flush_cnt_q;

  logic load_use;
  logic muldiv_start;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_rd)) ||
                     (id_uses_rt && (id_rt == ex_rd)));

  // muldiv_done stops the same instruction from re-entering MULDIV once
  // its stall has completed but it is still sitting in ID.
  assign muldiv_start = (state_q == S_RUN) && id_muldiv && !muldiv_done_q;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_RUN;
      cnt_q         <= 8'd0;
      muldiv_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      muldiv_done_q <= muldiv_done_d;
    end
  end

  // Next-state logic; a dmem_busy cycle freezes everything.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    muldiv_done_d = muldiv_done_q;
    if (!dmem_busy) begin
      case (state_q)
        S_RUN: begin
          if (muldiv_start) begin
            state_d = S_MULDIV;
            cnt_d   = CNT_LOAD;
          end
        end
        S_MULDIV: begin
          if (cnt_q == 8'd1) begin
            state_d       = S_RUN;
            cnt_d         = 8'd0;
            muldiv_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: begin
          state_d = S_RUN;
          cnt_d   = 8'd0;
        end
      endcase
      // The ID instruction leaves ID whenever IF/ID loads.
      if (if_id_write) muldiv_done_d = 1'b0;
    end
  end

  // Output logic, first matching rule wins.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    if (!reset_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (dmem_busy) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if ((state_q == S_MULDIV) || muldiv_start || load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end else if (id_branch_taken) begin
      // PC loads the target even if the current fetch is not ready.
      if_id_flush = 1'b1;
    end else if (!imem_ready) begin
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  // Saturating perf counters; clear wins over increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else if (counter_clear) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (!pc_write && (stall_cnt_q != CNT_MAX)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (if_id_flush && (flush_cnt_q != CNT_MAX)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (MULDIV_CYCLES = 4).
// Control outputs are compared as one 6-bit vector:
//   {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write}

module tb_pipeline_hazard_controller;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rs, id_uses_rt, id_muldiv, id_branch_taken;
  logic        ex_mem_read, imem_ready, dmem_busy, counter_clear;
  logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write;
  logic [31:0] stall_count, flush_count;

  int checks   = 0;
  int failures = 0;

  localparam logic [5:0] C_DEF    = 6'b110101;
  localparam logic [5:0] C_STALL  = 6'b000111;
  localparam logic [5:0] C_OFF    = 6'b000000;
  localparam logic [5:0] C_BRANCH = 6'b111101;
  localparam logic [5:0] C_FETCH  = 6'b011101;

  logic [5:0] ctrl;
  assign ctrl = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write};

  pipeline_hazard_controller #(.MULDIV_CYCLES(4)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_muldiv       (id_muldiv),
    .id_branch_taken (id_branch_taken),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .imem_ready      (imem_ready),
    .dmem_busy       (dmem_busy),
    .counter_clear   (counter_clear),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_write     (id_ex_write),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_write    (ex_mem_write),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_muldiv = 1'b0;
    id_branch_taken = 1'b0; ex_mem_read = 1'b0;
    imem_ready = 1'b1; dmem_busy = 1'b0; counter_clear = 1'b0;
  endtask

  task automatic load_use_rs5();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    #1;
    check("reset_ctrl", {26'd0, ctrl}, {26'd0, C_OFF});
    check("reset_stall_cnt", stall_count, 32'd0);
    check("reset_flush_cnt", flush_count, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    check("run_default", {26'd0, ctrl}, {26'd0, C_DEF});

    // Load-use on rs, then the same pattern with ex_rd = 0, then on rt.
    load_use_rs5();
    #1; check("lu_rs_stall", {26'd0, ctrl}, {26'd0, C_STALL});
    tick();
    ex_rd = 5'd0; id_rs = 5'd0;
    #1; check("lu_rd0_none", {26'd0, ctrl}, {26'd0, C_DEF});
    check("lu_stall_cnt1", stall_count, 32'd1);
    tick();
    idle();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
    #1; check("lu_rt_stall", {26'd0, ctrl}, {26'd0, C_STALL});
    tick();
    id_uses_rt = 1'b0;
    #1; check("lu_rt_unused", {26'd0, ctrl}, {26'd0, C_DEF});
    check("lu_stall_cnt2", stall_count, 32'd2);
    tick();
    idle();

    // Mult/div: exactly 4 stall cycles, then the same instruction proceeds.
    id_muldiv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; check($sformatf("md_stall_%0d", i), {26'd0, ctrl}, {26'd0, C_STALL});
      tick();
    end
    #1; check("md_release", {26'd0, ctrl}, {26'd0, C_DEF});
    check("md_stall_cnt", stall_count, 32'd6);
    tick();

    // A new mult/div (muldiv_done cleared) with dmem_busy in its 2nd cycle.
    #1; check("md2_c1", {26'd0, ctrl}, {26'd0, C_STALL});
    tick();
    dmem_busy = 1'b1;
    #1; check("md2_busy", {26'd0, ctrl}, {26'd0, C_OFF});
    tick();
    dmem_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; check($sformatf("md2_stall_%0d", i), {26'd0, ctrl}, {26'd0, C_STALL});
      tick();
    end
    #1; check("md2_release", {26'd0, ctrl}, {26'd0, C_DEF});
    check("md2_stall_cnt", stall_count, 32'd11);
    check("md2_flush_cnt", flush_count, 32'd0);
    tick();
    idle();

    // Branch overrides fetch wait; load-use overrides branch.
    id_branch_taken = 1'b1; imem_ready = 1'b0;
    #1; check("br_fetchwait", {26'd0, ctrl}, {26'd0, C_BRANCH});
    tick();
    imem_ready = 1'b1;
    load_use_rs5();
    #1; check("br_vs_loaduse", {26'd0, ctrl}, {26'd0, C_STALL});
    tick();
    idle();
    #1;
    check("br_flush_cnt", flush_count, 32'd1);
    check("br_stall_cnt", stall_count, 32'd12);
    counter_clear = 1'b1;
    tick();
    counter_clear = 1'b0;
    #1;
    check("clr_stall_cnt", stall_count, 32'd0);
    check("clr_flush_cnt", flush_count, 32'd0);

    // Fetch wait for 3 cycles.
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; check($sformatf("fw_%0d", i), {26'd0, ctrl}, {26'd0, C_FETCH});
      tick();
    end
    imem_ready = 1'b1;
    #1;
    check("fw_stall_cnt", stall_count, 32'd3);
    check("fw_flush_cnt", flush_count, 32'd3);
    check("fw_done", {26'd0, ctrl}, {26'd0, C_DEF});

    // Reset in MULDIV with cnt = 2.
    id_muldiv = 1'b1;
    tick();
    tick();
    #1; check("rst_md_pre", {26'd0, ctrl}, {26'd0, C_STALL});
    reset_n = 1'b0;
    #1;
    check("rst_md_ctrl", {26'd0, ctrl}, {26'd0, C_OFF});
    check("rst_md_stall_cnt", stall_count, 32'd0);
    check("rst_md_flush_cnt", flush_count, 32'd0);
    tick();
    reset_n = 1'b1;
    id_muldiv = 1'b0;
    #1; check("rst_release_run", {26'd0, ctrl}, {26'd0, C_DEF});
    tick();
    id_muldiv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; check($sformatf("rst_md_stall_%0d", i), {26'd0, ctrl}, {26'd0, C_STALL});
      tick();
    end
    #1; check("rst_md_release", {26'd0, ctrl}, {26'd0, C_DEF});
    check("rst_md_cnt4", stall_count, 32'd4);
    tick();
    idle();

    // Saturation from a preloaded stall counter.
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    #1;
    check("sat_preload", stall_count, 32'hFFFF_FFFE);
    imem_ready = 1'b0;
    tick();
    #1; check("sat_first", stall_count, 32'hFFFF_FFFF);
    tick();
    tick();
    #1; check("sat_hold", stall_count, 32'hFFFF_FFFF);
    imem_ready = 1'b1;

    // Clear has priority over a simultaneous stall.
    load_use_rs5();
    counter_clear = 1'b1;
    #1; check("clr_stall_ctrl", {26'd0, ctrl}, {26'd0, C_STALL});
    tick();
    idle();
    #1;
    check("clr_prio_stall", stall_count, 32'd0);
    check("clr_prio_flush", flush_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall/flush sequencer for the 5-stage pipeline. It drives the write-enable and flush controls of the PC, the IF/ID register and the downstream pipeline registers from:
- load-use hazards,
- taken branches resolved in ID,
- instruction-fetch wait,
- data-memory wait,
- multi-cycle mult/div instructions.

It also keeps saturating stall and flush performance counters.

## Interface
- MULDIV_CYCLES, 4, total front-end stall cycles for a mult/div held in ID; legal range 2..255
- clock  in  1  pipeline clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_muldiv  in  1  ID instruction is mult/div
- id_branch_taken  in  1  branch in ID resolved taken this cycle
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  5  destination register of EX instruction
- imem_ready  in  1  fetch data valid this cycle
- dmem_busy  in  1  MEM stage access not complete
- counter_clear  in  1  synchronous clear of both perf counters
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID loads a NOP (valid only with if_id_write=1)
- id_ex_write  out  1  ID/EX load enable
- id_ex_flush  out  1  ID/EX loads a bubble
- ex_mem_write  out  1  EX/MEM load enable
- stall_count  out  32  cycles with pc_write=0 while out of reset
- flush_count  out  32  cycles with if_id_flush=1

## Operation
**Registered state**
- state: RUN or MULDIV.
- cnt: 8-bit down-counter.
- muldiv_done: 1-bit flag.
- The two perf counters.

**Control outputs**
- Combinational from state and inputs.
- The first matching rule wins.
- Any control output not listed in a rule is in its default: all write enables 1, both flushes 0.

**Priority rules**
1. reset_n=0: all write enables 0, all flushes 0.
2. dmem_busy=1: pc_write, if_id_write, id_ex_write and ex_mem_write all 0; no flush. state, cnt and muldiv_done hold.
3. state=MULDIV: pc_write=0, if_id_write=0, id_ex_flush=1.
4. RUN with id_muldiv=1 and muldiv_done=0: same outputs as rule 3. Next state MULDIV, cnt←MULDIV_CYCLES−1.
5. Load-use hazard: pc_write=0, if_id_write=0, id_ex_flush=1.
   - Condition: ex_mem_read=1, ex_rd≠0, and either (id_uses_rs=1 and id_rs=ex_rd) or (id_uses_rt=1 and id_rt=ex_rd).
6. id_branch_taken=1: if_id_flush=1; pc_write=1 loads the target. This rule overrides imem_ready=0.
7. imem_ready=0: pc_write=0, if_id_flush=1 (bubble into ID).
8. Otherwise: defaults.

**MULDIV state**
- Applies only when dmem_busy=0.
- cnt decrements each cycle.
- When cnt=1 at a rising edge: next state RUN, cnt←0, muldiv_done←1.

**muldiv_done**
- Clears on any edge where if_id_write=1, i.e. the instruction leaves ID.
- Suppresses re-triggering rule 4 for the same instruction.

**Counters**
- Both counters are 32-bit and saturate at 0xFFFFFFFF.
- counter_clear has priority over increment.
- They increment on the edge ending a qualifying cycle. They do not count while reset_n=0.

## Timing
- Reset values: state=RUN, cnt=0, muldiv_done=0, stall_count=0, flush_count=0.
- Reset mid-MULDIV aborts to RUN immediately, asynchronously.
- After reset_n deasserts, the first cycle decodes from RUN.
- Load-use stall:
  - Exactly 1 cycle per hazard, no state.
  - Next cycle the load is in MEM.
  - A taken branch in the same cycle is ignored; it is re-evaluated next cycle.
- Mult/div stall:
  - The front end stalls for exactly MULDIV_CYCLES consecutive cycles, excluding dmem_busy cycles.
  - A dmem_busy cycle extends the stall 1:1.
  - The cycle after the stall ends, RUN rules 5–8 apply to the same ID instruction.
- Taken-branch flush: 1 cycle.
- Fetch-wait bubbles: 1 per cycle of imem_ready=0.
- All outputs are valid combinationally within the cycle. There is no output register.

## Test plan
1. **Load-use:** ex_mem_read=1, ex_rd=5, id_rs=5, id_uses_rs=1 for 1 cycle → pc_write=0, if_id_write=0, id_ex_flush=1 for 1 cycle; stall_count=1. Repeat with ex_rd=0 → no stall.
2. **Mult/div, default MULDIV_CYCLES=4:** id_muldiv=1 held → stall outputs for exactly 4 cycles, then pc_write=if_id_write=1 and muldiv_done cleared. Inject dmem_busy=1 during cycle 2 → stall lasts 5 cycles and all write enables are 0 that cycle.
3. **Branch:**
   - id_branch_taken=1 with imem_ready=0 → pc_write=1, if_id_flush=1; flush_count increments.
   - Branch together with a load-use hazard → only the stall outputs.
4. **Fetch wait:** imem_ready=0 for 3 cycles → 3 cycles of pc_write=0, if_id_flush=1; stall_count=3, flush_count=3.
5. **Reset:** reset_n=0 during MULDIV with cnt=2 → immediately all write enables 0, state=RUN, counters 0. After release → normal RUN decode.
6. **Counters:**
   - Preload stall_count near saturation by forcing 0xFFFFFFFE, then stall 3 cycles → reads 0xFFFFFFFF.
   - counter_clear with a simultaneous stall → reads 0.
